blur_window_feeder: RTL
=======================

Name: blur_window_feeder

Overview:
Producer side of the 3x3 blur window interface. Reads a grayscale image from a single-port BRAM and emits one 3x3 neighbourhood per output pixel on r0/r1/r2 with a valid, for consumption by the gaussian blur stage. Borders are handled by edge replication, so exactly IMG_WIDTH*IMG_HEIGHT windows are emitted per frame. Sits between the frame BRAM and the gaussian stage; throttled by the blur stage's busy signal through ready_in.

Parameters:
PIX_WIDTH, 8, bits per pixel
IMG_WIDTH, 64, image columns (>=1)
IMG_HEIGHT, 64, image rows (>=1)
BRAM_LATENCY, 2, cycles from addr_out to valid pixel_in
ADDR_WIDTH, $clog2(IMG_WIDTH*IMG_HEIGHT), BRAM address width

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, synchronous, active-high
start_in  input  1  one-cycle pulse; begins a frame when idle
addr_out  output  ADDR_WIDTH  BRAM read address, row*IMG_WIDTH+col
pixel_in  input  PIX_WIDTH  BRAM read data, BRAM_LATENCY after addr_out
r0_data_out  output  3*PIX_WIDTH  row y-1 (clamped); MSB byte = col x-1, middle = x, LSB = x+1
r1_data_out  output  3*PIX_WIDTH  row y, same packing
r2_data_out  output  3*PIX_WIDTH  row y+1 (clamped), same packing
data_valid_out  output  1  window valid
ready_in  input  1  consumer can accept (driven from !busy of blur stage)
busy_out  output  1  high from start accepted until done
done_out  output  1  one-cycle pulse after last window transfers

Behaviour:
- Reset: all outputs 0, state IDLE, x=y=0, window registers 0. Reset mid-frame aborts immediately; no done_out.
- Clamp: c(k)=min(max(k,0),DIM-1) on both axes. Pixel (x,y) window = P[c(y+i)][c(x+j)], i,j in {-1,0,1}.
- States: IDLE -> ROW_START -> FETCH -> EMIT -> (FETCH | ROW_START | IDLE).
- IDLE: start_in high -> busy_out=1, x=0, y=0, ROW_START. start_in ignored in any other state.
- ROW_START: issue 3 reads, one per cycle, column 0, rows c(y-1), y, c(y+1); when all returned (3+BRAM_LATENCY cycles), load into both left and centre columns; go FETCH.
- FETCH: issue 3 reads of column c(x+1), same row order; after 3+BRAM_LATENCY cycles load right column; go EMIT.
- EMIT: data_valid_out=1, r*_data_out stable until cycle with ready_in=1 (transfer). Valid may not drop before transfer. On transfer: valid=0 next cycle; if x<IMG_WIDTH-1: left<=centre, centre<=right, x++, FETCH; else if y<IMG_HEIGHT-1: x=0, y++, ROW_START; else IDLE, busy_out=0, done_out=1 for one cycle.
- Timing with ready_in held high: first data_valid_out exactly 2*(3+BRAM_LATENCY)+1 cycles after start_in sampled (11 at defaults); subsequent windows in a row every 3+BRAM_LATENCY+1 cycles (6).
- addr_out holds last issued address when not reading; reads have no side effects.
- No arithmetic beyond address: row*IMG_WIDTH+col computed at ADDR_WIDTH, never overflows by construction.
- IMG_WIDTH=1 or IMG_HEIGHT=1: clamping makes all relevant columns/rows identical; no special path.

Decomposition:
- Shared package blur_pkg: window_row_t (3*PIX_WIDTH packed), feeder state enum, clamp function.
- One sub-module natural: column_fetch (issues 3 reads for a given column/row triple, waits BRAM_LATENCY, returns 3 pixels with done pulse); used by ROW_START and FETCH.

Test Plan:
- 3x3 image 1..9 row-major, ready_in=1: window (1,1) = r0 01_02_03, r1 04_05_06, r2 07_08_09; window (0,0) = 01_01_02 / 01_01_02 / 04_04_05; window (2,2) = 05_06_06 / 08_09_09 / 08_09_09; 9 windows total then done_out one pulse.
- Timing: start at cycle T -> first data_valid_out at T+11, second at T+17; busy_out high T+1 through done.
- Backpressure: ready_in low 5 cycles during EMIT -> data_valid_out and r*_data_out unchanged, no extra window, no skipped window.
- 1x1 image value 0xFF -> one window all FF_FF_FF on r0/r1/r2, then done_out.
- start_in pulsed mid-frame -> ignored, window count still IMG_WIDTH*IMG_HEIGHT; rst_in mid-frame -> all outputs 0 next cycle, no done_out, fresh start_in runs full frame correctly.
- Random 8x6 image vs software clamped-window model: all 48 windows match in raster order.

Source files
------------

// File: rtl/blur_window_feeder_pkg.sv
// Shared types and helpers for the 3x3 blur window feeder: state encoding,
// default window row type and the border clamp used on both image axes.
package blur_pkg;

  localparam int PIX_WIDTH_DEF = 8;

  typedef logic [3*PIX_WIDTH_DEF-1:0] window_row_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROW_START,
    ST_FETCH,
    ST_EMIT
  } feeder_state_t;

  // Edge replication: coordinates outside the image snap to the nearest edge.
  function automatic int clampCoord(input int k, input int dim);
    if (k < 0) return 0;
    if (k > dim - 1) return dim - 1;
    return k;
  endfunction

endpackage

// File: rtl/blur_window_feeder_if.sv
// Feeder-side bundle: frame control, BRAM read port and the 3-row window stream.
interface blur_window_feeder_if #(
  parameter int PIX_WIDTH  = 8,
  parameter int ADDR_WIDTH = 12
);
  logic                   start_in;
  logic [ADDR_WIDTH-1:0]  addr_out;
  logic [PIX_WIDTH-1:0]   pixel_in;
  logic [3*PIX_WIDTH-1:0] r0_data_out;
  logic [3*PIX_WIDTH-1:0] r1_data_out;
  logic [3*PIX_WIDTH-1:0] r2_data_out;
  logic                   data_valid_out;
  logic                   ready_in;
  logic                   busy_out;
  logic                   done_out;

  modport master (
    input  start_in, pixel_in, ready_in,
    output addr_out, r0_data_out, r1_data_out, r2_data_out,
           data_valid_out, busy_out, done_out
  );

  modport slave (
    output start_in, pixel_in, ready_in,
    input  addr_out, r0_data_out, r1_data_out, r2_data_out,
           data_valid_out, busy_out, done_out
  );
endinterface

// File: rtl/blur_window_feeder_column_fetch.sv
// Reads one image column as a (top, middle, bottom) pixel triple from the BRAM,
// one address per cycle, and flags the cycle in which the last pixel arrives.
module column_fetch #(
  parameter int PIX_WIDTH    = 8,
  parameter int IMG_WIDTH    = 64,
  parameter int BRAM_LATENCY = 2,
  parameter int ADDR_WIDTH   = 12
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   i_go,
  input  logic [ADDR_WIDTH-1:0]  i_col,
  input  logic [ADDR_WIDTH-1:0]  i_row0,
  input  logic [ADDR_WIDTH-1:0]  i_row1,
  input  logic [ADDR_WIDTH-1:0]  i_row2,
  input  logic [PIX_WIDTH-1:0]   i_pixel,
  output logic [ADDR_WIDTH-1:0]  o_addr,
  output logic                   o_done,
  output logic [3*PIX_WIDTH-1:0] o_column
);

  localparam int PHASE_W = $clog2(BRAM_LATENCY + 3);
  localparam logic [PHASE_W-1:0] PH_PIX0 = PHASE_W'(BRAM_LATENCY);
  localparam logic [PHASE_W-1:0] PH_PIX1 = PHASE_W'(BRAM_LATENCY + 1);
  localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(BRAM_LATENCY + 2);
  localparam logic [ADDR_WIDTH-1:0] W_AW = ADDR_WIDTH'(IMG_WIDTH);

  logic                  r_active;
  logic [PHASE_W-1:0]    r_phase;
  logic [ADDR_WIDTH-1:0] r_col;
  logic [ADDR_WIDTH-1:0] r_row1;
  logic [ADDR_WIDTH-1:0] r_row2;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [PIX_WIDTH-1:0]  r_pix0;
  logic [PIX_WIDTH-1:0]  r_pix1;

  // Phase k of a fetch has read k on the bus; its data shows up at phase k+latency.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_active <= 1'b0;
      r_phase  <= '0;
      r_col    <= '0;
      r_row1   <= '0;
      r_row2   <= '0;
      r_addr   <= '0;
      r_pix0   <= '0;
      r_pix1   <= '0;
    end else if (i_go) begin
      r_active <= 1'b1;
      r_phase  <= '0;
      r_col    <= i_col;
      r_row1   <= i_row1;
      r_row2   <= i_row2;
      r_addr   <= i_row0 * W_AW + i_col;
    end else if (r_active) begin
      r_phase <= r_phase + PHASE_W'(1);
      if (r_phase == PHASE_W'(0)) r_addr <= r_row1 * W_AW + r_col;
      if (r_phase == PHASE_W'(1)) r_addr <= r_row2 * W_AW + r_col;
      if (r_phase == PH_PIX0) r_pix0 <= i_pixel;
      if (r_phase == PH_PIX1) r_pix1 <= i_pixel;
      if (o_done) r_active <= 1'b0;
    end
  end

  // The bottom pixel is handed over straight from the BRAM in its arrival cycle.
  assign o_done   = r_active && (r_phase == PH_LAST);
  assign o_column = {r_pix0, r_pix1, i_pixel};
  assign o_addr   = r_addr;

endmodule

// File: rtl/blur_window_feeder.sv
// Walks the frame in raster order and presents one edge-replicated 3x3 window
// per pixel, sliding the window one column at a time along each row.
module blur_window_feeder
  import blur_pkg::*;
#(
  parameter int PIX_WIDTH    = 8,
  parameter int IMG_WIDTH    = 64,
  parameter int IMG_HEIGHT   = 64,
  parameter int BRAM_LATENCY = 2,
  parameter int ADDR_WIDTH   = ($clog2(IMG_WIDTH * IMG_HEIGHT) > 0) ?
                               $clog2(IMG_WIDTH * IMG_HEIGHT) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  blur_window_feeder_if.master bus
);

  localparam int XW = $clog2(IMG_WIDTH + 1);
  localparam int YW = $clog2(IMG_HEIGHT + 1);
  localparam int CW = 3 * PIX_WIDTH;

  feeder_state_t         r_state;
  feeder_state_t         w_nextState;
  logic [XW-1:0]         r_x;
  logic [YW-1:0]         r_y;
  logic [CW-1:0]         r_left;
  logic [CW-1:0]         r_centre;
  logic [CW-1:0]         r_right;
  logic                  r_done;
  logic                  w_go;
  logic                  w_fetchDone;
  logic                  w_lastCol;
  logic                  w_lastRow;
  logic                  w_transfer;
  int                    w_fetchX;
  int                    w_fetchY;
  logic [ADDR_WIDTH-1:0] w_col;
  logic [ADDR_WIDTH-1:0] w_row0;
  logic [ADDR_WIDTH-1:0] w_row1;
  logic [ADDR_WIDTH-1:0] w_row2;
  logic [CW-1:0]         w_column;

  assign w_lastCol  = (int'(r_x) == IMG_WIDTH - 1);
  assign w_lastRow  = (int'(r_y) == IMG_HEIGHT - 1);
  assign w_transfer = (r_state == ST_EMIT) && bus.ready_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  // Every fetch is launched on the edge that enters ROW_START/FETCH, so the
  // column/row it targets must be computed from the coordinates it will have.
  always_comb begin
    w_nextState = r_state;
    w_go        = 1'b0;
    w_fetchX    = 0;
    w_fetchY    = int'(r_y);
    case (r_state)
      ST_IDLE: begin
        if (bus.start_in) begin
          w_nextState = ST_ROW_START;
          w_go        = 1'b1;
          w_fetchY    = 0;
        end
      end
      ST_ROW_START: begin
        if (w_fetchDone) begin
          w_nextState = ST_FETCH;
          w_go        = 1'b1;
          w_fetchX    = int'(r_x) + 1;
        end
      end
      ST_FETCH: begin
        if (w_fetchDone) w_nextState = ST_EMIT;
      end
      ST_EMIT: begin
        if (bus.ready_in) begin
          if (!w_lastCol) begin
            w_nextState = ST_FETCH;
            w_go        = 1'b1;
            w_fetchX    = int'(r_x) + 2;
          end else if (!w_lastRow) begin
            w_nextState = ST_ROW_START;
            w_go        = 1'b1;
            w_fetchY    = int'(r_y) + 1;
          end else begin
            w_nextState = ST_IDLE;
          end
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  assign w_col  = ADDR_WIDTH'(clampCoord(w_fetchX, IMG_WIDTH));
  assign w_row0 = ADDR_WIDTH'(clampCoord(w_fetchY - 1, IMG_HEIGHT));
  assign w_row1 = ADDR_WIDTH'(clampCoord(w_fetchY, IMG_HEIGHT));
  assign w_row2 = ADDR_WIDTH'(clampCoord(w_fetchY + 1, IMG_HEIGHT));

  // Row start fills left and centre with column 0, which replicates the left edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_x      <= '0;
      r_y      <= '0;
      r_left   <= '0;
      r_centre <= '0;
      r_right  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_transfer && w_lastCol && w_lastRow;
      case (r_state)
        ST_IDLE: begin
          if (bus.start_in) begin
            r_x <= '0;
            r_y <= '0;
          end
        end
        ST_ROW_START: begin
          if (w_fetchDone) begin
            r_left   <= w_column;
            r_centre <= w_column;
          end
        end
        ST_FETCH: begin
          if (w_fetchDone) r_right <= w_column;
        end
        ST_EMIT: begin
          if (bus.ready_in) begin
            if (!w_lastCol) begin
              r_left   <= r_centre;
              r_centre <= r_right;
              r_x      <= r_x + XW'(1);
            end else if (!w_lastRow) begin
              r_x <= '0;
              r_y <= r_y + YW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  column_fetch #(
    .PIX_WIDTH   (PIX_WIDTH),
    .IMG_WIDTH   (IMG_WIDTH),
    .BRAM_LATENCY(BRAM_LATENCY),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_fetch (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_go    (w_go),
    .i_col   (w_col),
    .i_row0  (w_row0),
    .i_row1  (w_row1),
    .i_row2  (w_row2),
    .i_pixel (bus.pixel_in),
    .o_addr  (bus.addr_out),
    .o_done  (w_fetchDone),
    .o_column(w_column)
  );

  assign bus.r0_data_out    = {r_left[CW-1 -: PIX_WIDTH], r_centre[CW-1 -: PIX_WIDTH],
                               r_right[CW-1 -: PIX_WIDTH]};
  assign bus.r1_data_out    = {r_left[2*PIX_WIDTH-1 -: PIX_WIDTH],
                               r_centre[2*PIX_WIDTH-1 -: PIX_WIDTH],
                               r_right[2*PIX_WIDTH-1 -: PIX_WIDTH]};
  assign bus.r2_data_out    = {r_left[PIX_WIDTH-1:0], r_centre[PIX_WIDTH-1:0],
                               r_right[PIX_WIDTH-1:0]};
  assign bus.data_valid_out = (r_state == ST_EMIT);
  assign bus.busy_out       = (r_state != ST_IDLE);
  assign bus.done_out       = r_done;

endmodule
